serial_subtractor: RTL and testbench

- Bit-serial subtractor computing diff = a - b - b_in, LSB first, one bit per clock, using a single full-subtractor cell and a borrow flip-flop.
- Arithmetic companion to the full-adder blocks: the subtract direction of the same add/subtract datapath, for area-constrained ALU paths.
- Operands are accepted via a valid/ready handshake. The result is returned via a valid/ready handshake.

---
 rtl/serial_subtractor.sv | 131 +++++++++++++
 tb/tb_serial_subtractor.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: diff = a - b - b_in, LSB first, one bit per clock,
// built around a single full-subtractor cell and a borrow flip-flop.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             b_in,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] diff,
  output logic             b_out,
  output logic             ovf,
  output logic             busy
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // One full-subtractor cell: returns {borrow_out, difference_bit}.
  function automatic logic [1:0] full_sub(input logic x, input logic y, input logic bi);
    logic d;
    logic bo;
    d  = x ^ y ^ bi;
    bo = (~x & y) | (~(x ^ y) & bi);
    return {bo, d};
  endfunction

  state_t           state_r;
  logic [WIDTH-1:0] ra_r;
  logic [WIDTH-1:0] rb_r;
  logic             br_r;
  logic             sa_r;
  logic             sb_r;
  logic [CNT_W-1:0] cnt_r;

  logic             d_s;
  logic             br_next_s;
  logic             last_s;

  // Current-bit difference, next borrow and final-bit detection.
  always_comb begin
    d_s       = 1'b0;
    br_next_s = 1'b0;
    {br_next_s, d_s} = full_sub(ra_r[0], rb_r[0], br_r);
    if (cnt_r == CNT_LAST) begin
      last_s = 1'b1;
    end else begin
      last_s = 1'b0;
    end
  end

  // Control FSM and datapath registers, all outputs registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      ra_r        <= '0;
      rb_r        <= '0;
      br_r        <= 1'b0;
      sa_r        <= 1'b0;
      sb_r        <= 1'b0;
      cnt_r       <= '0;
      start_ready <= 1'b1;
      res_valid   <= 1'b0;
      diff        <= '0;
      b_out       <= 1'b0;
      ovf         <= 1'b0;
      busy        <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (start_valid) begin
            ra_r        <= a;
            rb_r        <= b;
            br_r        <= b_in;
            sa_r        <= a[WIDTH-1];
            sb_r        <= b[WIDTH-1];
            cnt_r       <= '0;
            start_ready <= 1'b0;
            busy        <= 1'b1;
            state_r     <= SHIFT;
          end else begin
            start_ready <= 1'b1;
          end
        end
        SHIFT: begin
          diff <= {d_s, diff[WIDTH-1:1]};
          ra_r <= ra_r >> 1;
          rb_r <= rb_r >> 1;
          br_r <= br_next_s;
          if (last_s) begin
            // Overflow only when operand signs differ and result sign leaves a's sign.
            b_out     <= br_next_s;
            ovf       <= (sa_r ^ sb_r) & (d_s ^ sa_r);
            res_valid <= 1'b1;
            state_r   <= DONE;
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        DONE: begin
          if (res_ready) begin
            res_valid   <= 1'b0;
            start_ready <= 1'b1;
            busy        <= 1'b0;
            state_r     <= IDLE;
          end else begin
            res_valid <= 1'b1;
          end
        end
        default: begin
          state_r     <= IDLE;
          start_ready <= 1'b1;
          res_valid   <= 1'b0;
          busy        <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed self-checking bench for serial_subtractor (WIDTH = 8).
module tb_serial_subtractor;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start_valid;
  logic             start_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             b_in;
  logic             res_valid;
  logic             res_ready;
  logic [WIDTH-1:0] diff;
  logic             b_out;
  logic             ovf;
  logic             busy;

  int checks = 0;
  int fails  = 0;
  int cyc    = 0;

  serial_subtractor #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst_n(rst_n), .start_valid(start_valid), .start_ready(start_ready),
    .a(a), .b(b), .b_in(b_in), .res_valid(res_valid), .res_ready(res_ready),
    .diff(diff), .b_out(b_out), .ovf(ovf), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Present operands for one edge (block is idle), then scramble the inputs.
  task automatic issue(input logic [7:0] ia, input logic [7:0] ib, input logic ibin);
    a = ia; b = ib; b_in = ibin; start_valid = 1'b1;
    @(posedge clk); #1;
    start_valid = 1'b0; a = ~ia; b = ~ib; b_in = ~ibin;
  endtask

  // Count edges until res_valid, bounded.
  task automatic wait_res(output int n);
    n = 0;
    while (n < 40) begin
      @(posedge clk); #1;
      n++;
      if (res_valid) break;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; start_valid = 1'b0; res_ready = 1'b1;
    a = 8'h00; b = 8'h00; b_in = 1'b0;
    #12;
    checks++;
    if ({start_ready, res_valid, diff, b_out, ovf, busy} !== {1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0}) begin
      fails++; $display("FAIL reset_in: got sr=%b rv=%b diff=%h bo=%b ovf=%b busy=%b expected 1 0 00 0 0 0",
                        start_ready, res_valid, diff, b_out, ovf, busy);
    end
    @(posedge clk); #1; rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({start_ready, res_valid, busy} !== {1'b1, 1'b0, 1'b0}) begin
      fails++; $display("FAIL reset_after: got sr=%b rv=%b busy=%b expected 1 0 0", start_ready, res_valid, busy);
    end
  endtask

  task automatic test_basic;
    int n;
    issue(8'h5A, 8'h3C, 1'b0);
    checks++;
    if ({start_ready, busy} !== {1'b0, 1'b1}) begin
      fails++; $display("FAIL basic_shift: got sr=%b busy=%b expected 0 1", start_ready, busy);
    end
    wait_res(n);
    checks++;
    if (n !== WIDTH) begin
      fails++; $display("FAIL basic_latency: got %0d expected %0d", n, WIDTH);
    end
    checks++;
    if ({diff, b_out, ovf} !== {8'h1E, 1'b0, 1'b0}) begin
      fails++; $display("FAIL basic_result: got diff=%h bo=%b ovf=%b expected 1e 0 0", diff, b_out, ovf);
    end
    @(posedge clk); #1;
    checks++;
    if ({res_valid, start_ready, busy} !== {1'b0, 1'b1, 1'b0}) begin
      fails++; $display("FAIL basic_accept: got rv=%b sr=%b busy=%b expected 0 1 0", res_valid, start_ready, busy);
    end
  endtask

  task automatic test_borrow;
    logic [7:0] va [2] = '{8'h00, 8'h10};
    logic [7:0] vb [2] = '{8'h01, 8'h0F};
    logic       vi [2] = '{1'b0, 1'b1};
    logic [7:0] ed [2] = '{8'hFF, 8'h00};
    logic       eb [2] = '{1'b1, 1'b0};
    int n;
    for (int i = 0; i < 2; i++) begin
      issue(va[i], vb[i], vi[i]);
      wait_res(n);
      checks++;
      if ({res_valid, diff, b_out, ovf} !== {1'b1, ed[i], eb[i], 1'b0}) begin
        fails++; $display("FAIL borrow_%0d: got rv=%b diff=%h bo=%b ovf=%b expected 1 %h %b 0",
                          i, res_valid, diff, b_out, ovf, ed[i], eb[i]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_overflow;
    logic [7:0] va [2] = '{8'h80, 8'h7F};
    logic [7:0] vb [2] = '{8'h01, 8'hFF};
    logic [7:0] ed [2] = '{8'h7F, 8'h80};
    logic       eb [2] = '{1'b0, 1'b1};
    int n;
    for (int i = 0; i < 2; i++) begin
      issue(va[i], vb[i], 1'b0);
      wait_res(n);
      checks++;
      if ({res_valid, diff, b_out, ovf} !== {1'b1, ed[i], eb[i], 1'b1}) begin
        fails++; $display("FAIL overflow_%0d: got rv=%b diff=%h bo=%b ovf=%b expected 1 %h %b 1",
                          i, res_valid, diff, b_out, ovf, ed[i], eb[i]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_backpressure;
    int n;
    res_ready = 1'b0;
    issue(8'h33, 8'h44, 1'b1);
    wait_res(n);
    checks++;
    if (n !== WIDTH) begin
      fails++; $display("FAIL bp_latency: got %0d expected %0d", n, WIDTH);
    end
    for (int i = 0; i < 5; i++) begin
      start_valid = 1'b1; a = 8'h01 + 8'(i); b = 8'h02; b_in = 1'b0;
      @(posedge clk); #1;
      checks++;
      if ({res_valid, start_ready, diff, b_out, ovf} !== {1'b1, 1'b0, 8'hEE, 1'b1, 1'b0}) begin
        fails++; $display("FAIL bp_hold_%0d: got rv=%b sr=%b diff=%h bo=%b ovf=%b expected 1 0 ee 1 0",
                          i, res_valid, start_ready, diff, b_out, ovf);
      end
    end
    start_valid = 1'b0; res_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({res_valid, start_ready} !== {1'b0, 1'b1}) begin
      fails++; $display("FAIL bp_release: got rv=%b sr=%b expected 0 1", res_valid, start_ready);
    end
  endtask

  task automatic test_reset_mid;
    int n;
    logic seen;
    issue(8'h12, 8'h34, 1'b0);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({start_ready, res_valid, diff, b_out, ovf, busy} !== {1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0}) begin
      fails++; $display("FAIL mid_reset: got sr=%b rv=%b diff=%h bo=%b ovf=%b busy=%b expected 1 0 00 0 0 0",
                        start_ready, res_valid, diff, b_out, ovf, busy);
    end
    seen = 1'b0;
    repeat (10) begin
      @(posedge clk); #1;
      seen = seen | res_valid;
    end
    checks++;
    if (seen !== 1'b0) begin
      fails++; $display("FAIL mid_no_pulse: got res_valid pulse=%b expected 0", seen);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    issue(8'hFF, 8'hFF, 1'b0);
    wait_res(n);
    checks++;
    if ({n == WIDTH, diff, b_out, ovf} !== {1'b1, 8'h00, 1'b0, 1'b0}) begin
      fails++; $display("FAIL mid_after: got n=%0d diff=%h bo=%b ovf=%b expected 8 00 0 0", n, diff, b_out, ovf);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back;
    logic [7:0] va [4] = '{8'hA5, 8'h01, 8'hC8, 8'h7F};
    logic [7:0] vb [4] = '{8'h5A, 8'h02, 8'h37, 8'h80};
    logic       vi [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    logic [8:0] full;
    logic       eovf;
    int n, k, acc, prev_acc;
    res_ready = 1'b1;
    prev_acc = 0;
    for (int i = 0; i < 4; i++) begin
      a = va[i]; b = vb[i]; b_in = vi[i]; start_valid = 1'b1;
      k = 0;
      while (!start_ready && k < 40) begin
        @(posedge clk); #1;
        k++;
      end
      @(posedge clk); #1;
      acc = cyc;
      a = ~va[i]; b = ~vb[i]; b_in = ~vi[i];
      if (i == 3) start_valid = 1'b0;
      if (i > 0) begin
        checks++;
        if (acc - prev_acc !== WIDTH + 2) begin
          fails++; $display("FAIL b2b_interval_%0d: got %0d expected %0d", i, acc - prev_acc, WIDTH + 2);
        end
      end
      prev_acc = acc;
      wait_res(n);
      full = {1'b0, va[i]} - {1'b0, vb[i]} - {8'h00, vi[i]};
      eovf = (va[i][7] ^ vb[i][7]) & (full[7] ^ va[i][7]);
      checks++;
      if ({n == WIDTH, diff, b_out, ovf} !== {1'b1, full[7:0], full[8], eovf}) begin
        fails++; $display("FAIL b2b_result_%0d: got n=%0d diff=%h bo=%b ovf=%b expected 8 %h %b %b",
                          i, n, diff, b_out, ovf, full[7:0], full[8], eovf);
      end
    end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_borrow();
    test_overflow();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
